// File: rtl/lcd_strobe_pio.sv
// Avalon-MM output port for LCD control lines, with atomic set/clear
// registers and a hardware strobe engine that inverts masked lines for PULSE_CYCLES clocks.
module lcd_strobe_pio #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    localparam int             CW       = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(PULSE_CYCLES - 1);

    typedef enum logic {IDLE, PULSE} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             done, done_d;
    logic [WIDTH-1:0] data_reg, pulse_mask, pulse_mask_d;
    logic             wr;
    logic [WIDTH-1:0] wd;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                2'd0:    data_reg <= wd;
                2'd1:    data_reg <= data_reg | wd;
                2'd2:    data_reg <= data_reg & ~wd;
                default: data_reg <= data_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            pulse_mask <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            done       <= done_d;
            pulse_mask <= pulse_mask_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        done_d       = done;
        pulse_mask_d = pulse_mask;
        case (state)
            IDLE: begin
                if (wr && address == 2'd3) begin
                    done_d = 1'b0;
                    if (wd != '0) begin
                        pulse_mask_d = wd;
                        cnt_d        = CNT_LOAD;
                        state_d      = PULSE;
                    end
                end
            end
            PULSE: begin
                // PULSE writes are dropped here, including in the terminal-count cycle.
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_port = data_reg ^ ((state == PULSE) ? pulse_mask : '0);

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = data_reg;
            2'd1,
            2'd2:    readdata[WIDTH-1:0] = pulse_mask;
            default: readdata[1:0]       = {done, state == PULSE};
        endcase
    end
endmodule

// File: doc/lcd_strobe_pio.md
# lcd_strobe_pio

Parametrised Avalon-MM output port driving WIDTH LCD control lines (RD, WR, CS, RS, backlight) from the Nios II system. It adds atomic bit set and clear registers, so software can change one line without a read-modify-write. It also has a hardware pulse engine that inverts selected lines for a fixed number of clocks, so software does not have to time LCD strobes. Sits on the system interconnect as an e_avalon_slave, one instance per LCD control group.

## Interface
Parameters:
- WIDTH, 8: number of output lines, legal 1..32.
- RESET_VALUE, 0: value of the data register and out_port after reset, WIDTH bits.
- PULSE_CYCLES, 4: strobe length in clk cycles, legal 1..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  input  32  write data; only bits [WIDTH-1:0] are used.
- readdata  output  32  combinational read mux; unused upper bits are 0.
- out_port  output  WIDTH  control lines to the LCD pins.

## Operation
- Registers:
  - data_reg: WIDTH bits.
  - pulse_mask: WIDTH bits.
  - state: IDLE or PULSE.
  - cnt: ceil(log2(PULSE_CYCLES)) bits, minimum 1.
  - done: 1 bit, sticky.
- Address map, writes:
  - 0 DATA: data_reg <= writedata[WIDTH-1:0].
  - 1 SET: data_reg <= data_reg | writedata[WIDTH-1:0].
  - 2 CLEAR: data_reg <= data_reg & ~writedata[WIDTH-1:0].
  - 3 PULSE:
    - In IDLE with nonzero mask: pulse_mask <= mask, cnt <= PULSE_CYCLES-1, state <= PULSE, done <= 0.
    - In IDLE with mask 0: done <= 0, stays IDLE.
    - In PULSE: write ignored entirely.
- Address map, reads (readdata):
  - 0: zero-extended data_reg. This is the register, not the live pulsed output.
  - 1, 2: zero-extended pulse_mask.
  - 3: bit0 = busy (state==PULSE), bit1 = done, bits [31:2] = 0.
- State machine:
  - IDLE -> PULSE: on a valid PULSE write.
  - PULSE with cnt != 0: cnt <= cnt-1.
  - PULSE with cnt == 0: state <= IDLE, done <= 1.
- out_port = data_reg ^ (state==PULSE ? pulse_mask : 0).
  - Combinational from registers only; no input-to-output path.
- Writes to DATA, SET or CLEAR during PULSE are accepted immediately. The inversion is applied on top of the new data_reg value.
- pulse_mask persists after the pulse ends. It only changes on the next accepted PULSE write.
- Reset (asynchronous, any time including mid-pulse):
  - data_reg = RESET_VALUE, pulse_mask = 0, state = IDLE, cnt = 0, done = 0.
  - Hence out_port = RESET_VALUE and readdata at address 3 reads 0.

## Timing
- No wait states; every write completes in the cycle it is presented.
- Register write at rising edge N: the new out_port value is visible immediately after edge N.
- PULSE write at edge N with PULSE_CYCLES=P:
  - busy=1 and out_port inverted from edge N through edge N+P.
  - Inversion lasts exactly P clk cycles.
  - At edge N+P: busy -> 0, done -> 1, out_port returns to data_reg.
- Back-to-back strobes: a PULSE write presented in the cycle after edge N+P is accepted. Minimum period is P+1 cycles, with at least one idle cycle between pulses.
- A PULSE write presented in the same cycle as the terminal count (cnt==0 in PULSE) is ignored. The engine is still busy in that cycle.
- P=1: a one-cycle strobe; cnt is loaded with 0 and the engine ends on the next edge.
- Reads are combinational: readdata is valid in the same cycle as address and reflects register state before that cycle's edge.

## Test plan
- Reset, WIDTH=8, RESET_VALUE=8'h0F:
  - Assert reset_n=0 mid-pulse -> out_port=8'h0F immediately, independent of clk; readdata at address 3 = 0.
  - Release reset -> values hold.
- Set/clear:
  - Write DATA=8'hA0, SET=8'h05, CLEAR=8'h80 -> out_port goes 8'hA0, then 8'hA5, then 8'h25; readdata at address 0 = 32'h25.
- Pulse, P=4:
  - data_reg=8'h03, write PULSE=8'h01 at edge N.
  - Required: out_port=8'h02 for exactly 4 cycles, busy=1 throughout, then out_port=8'h03 and address 3 reads 32'h2.
- Pulse while busy: a second PULSE=8'h02 write two cycles into a pulse is ignored. Mask stays 8'h01, pulse length stays 4 cycles, done is not cleared.
- Data write during pulse: during pulse mask 8'h01, write DATA=8'hF0 -> out_port=8'hF1 until the pulse ends, then 8'hF0.
- Edges:
  - P=1: single-cycle strobe.
  - Back-to-back PULSE writes spaced P+1 cycles apart: both accepted.
  - PULSE=0: no strobe, done cleared.
  - WIDTH=32: full-width mask 32'hFFFFFFFF inverts all lines.
